tweetboard: RTL and testbench

Serial "tweet" buffer: receives 8N1 UART characters on `serialIn`, stores up to 140 bytes in an internal buffer, and on a `btn_write` press replays the whole buffer in arrival order as 8N1 UART on `out`, then empties it. It is the top-level board block between a host serial link and a downstream serial consumer. Debug pins mirror the serial lines for probing.

---
 rtl/tweetboard.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_tweetboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweetboard.sv
// tweetboard: UART "tweet" buffer.
// Receives 8N1 bytes on serialIn into a DEPTH-byte buffer. A debounced press of
// btn_write replays the buffer back-to-back as 8N1 on out and then empties it.
// Optional feature macro: TWEETBOARD_DEBUG_EN. When it is defined, out_debug and
// in_debug mirror the serial lines. When it is not defined, both are tied high.
module tweetboard #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned DEPTH        = 140,
    parameter int unsigned DEBOUNCE_CYC = 50_000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic serialIn,
    input  logic btn_write,
    output logic out,
    output logic out_debug,
    output logic in_debug
);

    localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned BCW      = $clog2(BIT_CYC + 1);
    localparam int unsigned DCW      = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned CNTW     = $clog2(DEPTH + 1);
    localparam int unsigned PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [BCW-1:0]  BIT_LAST  = BCW'(BIT_CYC - 1);
    localparam logic [BCW-1:0]  HALF_LAST = BCW'(HALF_CYC - 1);
    localparam logic [DCW-1:0]  DEB_LAST  = DCW'(DEBOUNCE_CYC - 1);
    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Synchroniser and edge-history registers
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic btn_meta_q, btn_sync_q;

    // RX state
    logic [1:0]     rx_state_q, rx_state_d;
    logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_done_q, rx_done_d;

    // Debouncer state
    logic           deb_level_q, deb_level_d;
    logic           deb_prev_q;
    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic           btn_rise;

    // TX and buffer state
    logic [1:0]      tx_state_q, tx_state_d;
    logic [BCW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            out_q, out_d;
    logic            store;
    logic            tx_go;
    logic [7:0]      tx_byte;
    logic [7:0]      mem_q [DEPTH];

    // Two-flop synchronisers; RX history resets to the idle-high line level
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            rx_meta_q  <= serialIn;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            btn_meta_q <= btn_write;
            btn_sync_q <= btn_meta_q;
        end
    end

    // RX next state: mid-bit sampling, stop bit decides whether the byte is kept
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_done_d  = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX registers
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
        end
    end

    // Debouncer next state: level follows input only after a full stable run
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (btn_sync_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = btn_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debouncer registers
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            deb_level_q <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
        end else begin
            deb_level_q <= deb_level_d;
            deb_prev_q  <= deb_level_q;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    assign btn_rise = deb_level_q & ~deb_prev_q;
    // The buffer is frozen while TX runs; a full buffer drops new bytes.
    assign store    = rx_done_q && (tx_state_q == TX_IDLE) && (count_q != DEPTH_C);
    // A byte being stored this cycle counts toward starting TX, so a press that
    // coincides with completion still sends it.
    assign tx_go    = btn_rise && (tx_state_q == TX_IDLE) && ((count_q != '0) || store);
    assign tx_byte  = mem_q[rd_ptr_q];

    // TX next state: back-to-back frames until every buffered byte is sent
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        if (store) count_d = count_q + 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                out_d    = 1'b1;
                tx_cnt_d = '0;
                if (tx_go) begin
                    tx_state_d = TX_START;
                    out_d      = 1'b0;
                    rd_ptr_d   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    out_d      = tx_byte[0];
                    tx_shift_d = {1'b0, tx_byte[7:1]};
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        out_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        out_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (CNTW'(rd_ptr_q) + 1'b1 == count_q) begin
                        tx_state_d = TX_IDLE;
                        count_d    = '0;
                        rd_ptr_d   = '0;
                    end else begin
                        tx_state_d = TX_START;
                        out_d      = 1'b0;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX and buffer-occupancy registers
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
        end
    end

    // Buffer storage; contents are meaningful only below count_q
    always_ff @(posedge sysclk) begin
        if (store) mem_q[PTRW'(count_q)] <= rx_shift_q;
    end

    assign out = out_q;

`ifdef TWEETBOARD_DEBUG_EN
    assign out_debug = out_q;
    assign in_debug  = rx_sync_q;
`else
    assign out_debug = 1'b1;
    assign in_debug  = 1'b1;
`endif

endmodule

// File: tb/tb_tweetboard.sv
// Scoreboard bench for tweetboard, run with a scaled line rate
// (BIT_CYC = 8, DEBOUNCE_CYC = 20) so the 140-byte case stays short.
module tb_tweetboard;

    localparam int BIT   = 8;
    localparam int DEB   = 20;
    localparam int FRAME = 10 * BIT;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx_line = 1'b1;
    logic btn = 1'b0;
    logic out, out_debug, in_debug;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint tx_start = 0;
    int     dbg_bad = 0;
    logic   rx_d1 = 1'b1;
    logic   rx_d2 = 1'b1;
    logic [7:0] exp_q [$];

    tweetboard #(
        .CLK_HZ(80),
        .BAUD(10),
        .DEPTH(140),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .sysclk(clk),
        .reset(rstn),
        .serialIn(rx_line),
        .btn_write(btn),
        .out(out),
        .out_debug(out_debug),
        .in_debug(in_debug)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_line;
            rx_d2 <= rx_d1;
        end
    end

    always @(negedge clk) begin
`ifdef TWEETBOARD_DEBUG_EN
        if (out_debug !== out || in_debug !== rx_d2) dbg_bad++;
`else
        if (out_debug !== 1'b1 || in_debug !== 1'b1) dbg_bad++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (!rstn) ab = 1'b1;
        end
    endtask

    // Monitor: decode frames on out and pop the scoreboard
    initial begin
        bit     have_last;
        longint last_start;
        have_last  = 1'b0;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (!rstn) have_last = 1'b0;
            if (rstn && out === 1'b0) begin
                logic [7:0] b;
                logic       stopb;
                bit         ab;
                ab = 1'b0;
                b  = '0;
                if (have_last && (cyc - last_start) < 2 * FRAME)
                    check("frame_spacing", 32'(cyc - last_start), FRAME);
                last_start = cyc;
                have_last  = 1'b1;
                wait_cyc(BIT / 2, ab);
                if (!ab) check("start_bit_mid", {31'b0, out}, 0);
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(BIT, ab);
                    b[i] = out;
                end
                wait_cyc(BIT, ab);
                stopb = out;
                if (ab) begin
                    have_last = 1'b0;
                end else begin
                    check("stop_bit", {31'b0, stopb}, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%02h required=none", b);
                    end else begin
                        check("tx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_line = stopb;
        repeat (BIT) @(negedge clk);
        rx_line = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic press(input int hold, input bit expect_tx);
        int lat, bad;
        lat = 0;
        bad = 0;
        @(negedge clk);
        btn = 1'b1;
        if (expect_tx) begin
            while (out !== 1'b0 && lat < DEB + 10) begin
                @(negedge clk);
                lat++;
            end
            tx_start = cyc;
            checks++;
            if (lat < DEB || lat > DEB + 4) begin
                failures++;
                $display("FAIL tx_latency actual=%0d required=%0d..%0d", lat, DEB, DEB + 4);
            end
            repeat (hold) @(negedge clk);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                if (out !== 1'b1) bad++;
            end
        end
        btn = 1'b0;
        repeat (DEB + 5) begin
            @(negedge clk);
            if (!expect_tx && out !== 1'b1) bad++;
        end
        if (!expect_tx) check("idle_out_bad_cycles", bad, 0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (2 * FRAME) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pending;
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_out", {31'b0, out}, 1);
        check("rst_out_debug", {31'b0, out_debug}, 1);
        check("rst_in_debug", {31'b0, in_debug}, 1);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Three bytes, long press covering the whole burst (no retrigger)
        uart_send(8'h55, 1'b1);
        uart_send(8'hAA, 1'b1);
        uart_send(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        press(300, 1'b1);
        wait_drain(4 * FRAME);

        // Reset, then five 0xAA
        do_reset(40);
        @(negedge clk);
        check("rst2_out", {31'b0, out}, 1);
        for (int i = 0; i < 5; i++) begin
            uart_send(8'hAA, 1'b1);
            exp_q.push_back(8'hAA);
        end
        press(30, 1'b1);
        wait_drain(6 * FRAME);

        // Empty buffer press
        press(200, 1'b0);

        // Framing error byte dropped, then 0x41
        uart_send(8'h3C, 1'b0);
        uart_send(8'h41, 1'b1);
        exp_q.push_back(8'h41);
        press(30, 1'b1);
        wait_drain(2 * FRAME);

        // Overflow: 141 bytes sent, 140 kept
        for (int i = 0; i < 141; i++) uart_send(8'(i), 1'b1);
        for (int i = 0; i < 140; i++) exp_q.push_back(8'(i));
        press(40, 1'b1);
        wait_drain(141 * FRAME);

        // Reset in the middle of the third frame of a 5-byte burst
        for (int i = 0; i < 5; i++) begin
            uart_send(8'(8'h11 + i), 1'b1);
            exp_q.push_back(8'(8'h11 + i));
        end
        press(10, 1'b1);
        while (cyc < tx_start + 2 * FRAME + FRAME / 2) @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        pending = exp_q.size();
        @(negedge clk);
        check("abort_out", {31'b0, out}, 1);
        check("abort_pending", pending, 3);
        repeat (20) @(negedge clk);
        exp_q.delete();
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        press(100, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        check("final_pending", exp_q.size(), 0);
        check("debug_pins_bad_cycles", dbg_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
